// File: rtl/hfrv_trace_pkg.sv
// Shared types, opcode constants and the writeback decode used by the retire tracer.
// A trace record is {pc, instr, rd, wdata, stamp, flags}, 135 bits, MSB first.
package hfrv_trace_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int FLAG_HAS_WB     = 0;
    localparam int FLAG_WB_MISSING = 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] stamp;
        logic [1:0]  flags;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_WB = 1'b1
    } tracer_state_t;

    // CSR instructions write rd only when funct3 is non-zero (ECALL/EBREAK do not).
    function automatic logic needs_wb(input logic [31:0] instr);
        logic writes;
        writes = 1'b0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_OP_IMM, OP_OP: writes = 1'b1;
            OP_SYSTEM:                 writes = (instr[14:12] != 3'b000);
            default:                   writes = 1'b0;
        endcase
        return writes && (instr[11:7] != 5'd0);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered head output; push+pop is accepted while full.
// The head register always mirrors the oldest entry so the consumer sees it with no read latency.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 135
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_reg;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == (AW+1)'(DEPTH));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign head       = head_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            count_reg <= count_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
                // Next head comes from storage, or straight from the bypassed push when we drain to one.
                if (count_reg > (AW+1)'(1)) begin
                    head_reg <= mem[rd_ptr_inc];
                end else if (do_push) begin
                    head_reg <= push_data;
                end else begin
                    head_reg <= '0;
                end
            end else if (empty && do_push) begin
                head_reg <= push_data;
            end
        end
    end

endmodule

// File: rtl/retire_tracer.sv
// Pairs retired instructions with their register writeback, stamps them with a cycle count,
// and queues the records on a valid/ready stream for the verification monitor.
module retire_tracer
    import hfrv_trace_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WB_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ret_valid,
    input  logic [31:0]  ret_pc,
    input  logic [31:0]  ret_instr,
    input  logic         wb_en,
    input  logic [4:0]   wb_rd,
    input  logic [31:0]  wb_data,
    output logic         rec_valid,
    input  logic         rec_ready,
    output logic [134:0] rec_data,
    output logic         overflow,
    output logic [15:0]  drop_count
);

    localparam int TW = $clog2(WB_TIMEOUT + 1);

    tracer_state_t state_reg;
    tracer_state_t state_next;

    logic [31:0] stamp_reg;
    trace_rec_t  pend_reg;
    logic [TW-1:0] timer_reg;
    trace_rec_t  skid_reg;
    logic        skid_valid_reg;
    logic        overflow_reg;
    logic [15:0] drop_reg;

    logic [4:0]  ret_rd;
    logic        ret_needs;
    logic        wb_hit_pend;
    logic        wb_hit_ret;
    logic        in_wait;
    logic        close_pend;
    logic        imm_push;
    logic        open_new;
    logic        push_req;
    logic        to_skid;
    logic        pop;
    logic        drop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [REC_W-1:0] fifo_head;

    trace_rec_t  ret_base;
    trace_rec_t  imm_rec;
    trace_rec_t  open_rec;
    trace_rec_t  close_rec;
    trace_rec_t  push_rec;

    assign ret_rd      = ret_instr[11:7];
    assign ret_needs   = needs_wb(ret_instr);
    assign wb_hit_pend = wb_en && (wb_rd == pend_reg.rd);
    assign wb_hit_ret  = wb_en && (wb_rd == ret_rd);
    assign in_wait     = (state_reg == WAIT_WB);

    // Any retire while waiting closes the pending record, matched or not.
    assign close_pend = in_wait && (wb_hit_pend || ret_valid || (timer_reg == TW'(1)));
    assign imm_push   = ret_valid && (!ret_needs || wb_hit_ret);
    assign open_new   = ret_valid && ret_needs && !wb_hit_ret;

    // Only one push per cycle: skid first, then the closing record, then the new retire.
    assign push_req = skid_valid_reg || close_pend || imm_push;
    assign to_skid  = imm_push && (skid_valid_reg || close_pend);
    assign pop      = rec_valid && rec_ready;
    assign drop     = push_req && fifo_full && !pop;

    always_comb begin
        ret_base       = '0;
        ret_base.pc    = ret_pc;
        ret_base.instr = ret_instr;
        ret_base.stamp = stamp_reg;

        open_rec    = ret_base;
        open_rec.rd = ret_rd;

        imm_rec = ret_base;
        if (ret_needs) begin
            imm_rec.rd                 = ret_rd;
            imm_rec.wdata              = wb_data;
            imm_rec.flags[FLAG_HAS_WB] = 1'b1;
        end

        close_rec       = pend_reg;
        close_rec.wdata = '0;
        close_rec.flags = '0;
        if (wb_hit_pend) begin
            close_rec.wdata              = wb_data;
            close_rec.flags[FLAG_HAS_WB] = 1'b1;
        end else begin
            close_rec.flags[FLAG_WB_MISSING] = 1'b1;
        end

        push_rec = imm_rec;
        if (skid_valid_reg) begin
            push_rec = skid_reg;
        end else if (close_pend) begin
            push_rec = close_rec;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (open_new) begin
            state_next = WAIT_WB;
        end else if (close_pend) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stamp_reg      <= '0;
            pend_reg       <= '0;
            timer_reg      <= '0;
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            drop_reg       <= '0;
        end else begin
            stamp_reg <= stamp_reg + 1'b1;
            if (open_new) begin
                pend_reg  <= open_rec;
                timer_reg <= TW'(WB_TIMEOUT);
            end else if (in_wait) begin
                timer_reg <= timer_reg - 1'b1;
            end
            skid_valid_reg <= to_skid;
            if (to_skid) begin
                skid_reg <= imm_rec;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_reg != 16'hFFFF) begin
                    drop_reg <= drop_reg + 1'b1;
                end
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_rec),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rec_valid  = !fifo_empty;
    assign rec_data   = fifo_head;
    assign overflow   = overflow_reg;
    assign drop_count = drop_reg;

endmodule

// File: doc/retire_tracer.md
Name: retire_tracer

Overview:
- Hardware-side tracer between the HF-RISC core's retire/writeback signals and the verification monitor's snapshot/history callbacks.
- Pairs each retired instruction with its register writeback and timestamps it with a cycle stamp.
- Buffers the resulting records in a FIFO and presents them on a valid/ready stream that the monitor drains.

Parameters:
DEPTH, 16, trace FIFO entries; power of two, minimum 2.
WB_TIMEOUT, 8, cycles to wait for a writeback before closing a record as missing.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-low reset.
ret_valid  in  1  one-cycle pulse: an instruction retired.
ret_pc  in  32  PC of the retiring instruction.
ret_instr  in  32  encoding of the retiring instruction.
wb_en  in  1  register-file write strobe.
wb_rd  in  5  register-file write address.
wb_data  in  32  register-file write data.
rec_valid  out  1  output record available.
rec_ready  in  1  monitor accepts the record.
rec_data  out  135  trace_rec_t record: pc, instr, rd, wdata, stamp, flags[1:0] = {wb_missing, has_wb}.
overflow  out  1  sticky flag: at least one record dropped.
drop_count  out  16  number of dropped records; saturates at 0xFFFF.

Behaviour:
- Reset (reset==0 sampled at the clk edge): FSM to IDLE; FIFO emptied; rec_valid=0; rec_data=0; overflow=0; drop_count=0; cycle stamp=0.
- Cycle stamp: 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF->0. It is latched on ret_valid.
- needs_wb decode: rd=instr[11:7]!=0 and opcode in {0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011, 1110011 with funct3!=0}.
- FSM states: IDLE, WAIT_WB. One FIFO push per cycle maximum.
- IDLE + ret_valid, no writeback pending:
  - If !needs_wb: push {pc, instr, rd=0, wdata=0, stamp, flags=00}; stay in IDLE.
  - If needs_wb and wb_en && wb_rd==rd in the same cycle: push with wdata=wb_data, flags=01; stay in IDLE.
  - Otherwise: latch pending record, load timeout counter with WB_TIMEOUT, go to WAIT_WB.
- WAIT_WB, wb_en && wb_rd==pending rd: push with flags=01; go to IDLE.
  - A retire in the same cycle is then handled as in IDLE, except that a retire which would itself push goes to a 1-entry skid register and is pushed next cycle.
- WAIT_WB, writeback to a non-matching rd: ignored.
- WAIT_WB, timeout counter reaches 0: push pending record with flags=10, wdata=0; go to IDLE.
- WAIT_WB, ret_valid with no matching writeback: close pending with flags=10 (push), capture the new retire per the IDLE rules. An immediate push from the new retire uses the skid register.
- FIFO full at a push: record is dropped; overflow<=1; drop_count increments, saturating. A pop in the same cycle frees a slot first, so there is no drop.
- Output stream:
  - rec_valid = FIFO not empty; rec_data = head entry, registered and stable while rec_valid && !rec_ready.
  - Pop on rec_valid && rec_ready.
  - Records leave in retire order. First record is visible 1 cycle after its push.
- Reset mid-operation: the pending record, skid register and FIFO contents are discarded; no partial record is emitted.

Decomposition:
- Package hfrv_trace_pkg holds:
  - typedef trace_rec_t (packed struct, 135 bits).
  - Opcode localparams used by needs_wb.
  - Flag bit positions.
  - Function needs_wb(instr).
- One sub-module: trace_fifo. Synchronous FIFO, parameter DEPTH, generic width, push/pop/full/empty, simultaneous push+pop allowed when full.

Test Plan:
- ADDI x5,x0,7 (0x00700293) retire at stamp 10 with wb x5=7 in the same cycle -> one record: pc, instr, rd=5, wdata=7, stamp=10, flags=01; rec_valid next cycle.
- SW (opcode 0100011) retire -> immediate record, rd=0, flags=00. Then LW x6 retire with wb x6=0xDEADBEEF 3 cycles later -> record flags=01, wdata=0xDEADBEEF, stamp = retire cycle.
- ADDI x7 retire, no wb for WB_TIMEOUT=8 cycles -> record flags=10 pushed exactly 8 cycles after retire. A wb to x9 in between is ignored.
- Hold rec_ready=0, issue 20 non-writeback retires, DEPTH=16 -> 16 records kept, overflow=1, drop_count=4. Release rec_ready -> records emerge in order with rec_data stable while stalled.
- Pending x5 writeback coincides with a new SW retire -> two records in consecutive cycles, x5 first. Then reset=0 while WAIT_WB -> rec_valid=0, drop_count=0, no stale record after reset release.
